// File: rtl/tiny_boot_loader.sv
// Byte-stream program loader for the TinyMIPS blram: COUNT, {HI,LO} x N, CHK.
// Holds the core in reset while loading, then hands it the RAM port on a good checksum.
module tiny_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              cpu_wrEn,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic [2:0]        r_state;
  logic              r_ready;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_sum;
  logic [7:0]        r_hi;
  logic [7:0]        r_lo;

  logic [2:0]        w_next;
  logic              w_xfer;
  logic [7:0]        w_sum_next;
  logic [ADDR_W:0]   w_count;

  assign w_xfer     = in_valid & r_ready;
  assign w_sum_next = r_sum + in_data;

  // A COUNT byte of zero encodes a full 2**ADDR_W word image.
  always_comb begin
    w_count = '0;
    if (in_data == 8'd0) w_count[ADDR_W] = 1'b1;
    else                 w_count = (ADDR_W+1)'(in_data);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_xfer) w_next = S_HI;
      S_HI:   if (w_xfer) w_next = S_LO;
      S_LO:   if (w_xfer) w_next = S_WR;
      S_WR:   w_next = (r_rem == (ADDR_W+1)'(1)) ? S_CHK : S_HI;
      S_CHK:  if (w_xfer) w_next = (w_sum_next == 8'd0) ? S_RUN : S_ERR;
      S_RUN:  w_next = S_RUN;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it reads 0 during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_rem   <= '0;
      r_ptr   <= ADDR_W'(BASE_ADDR);
      r_sum   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE) || (w_next == S_HI) ||
                 (w_next == S_LO)   || (w_next == S_CHK);
      case (r_state)
        S_IDLE: if (w_xfer) begin
          r_rem <= w_count;
          r_sum <= in_data;
        end
        S_HI: if (w_xfer) begin
          r_hi  <= in_data;
          r_sum <= w_sum_next;
        end
        S_LO: if (w_xfer) begin
          r_lo  <= in_data;
          r_sum <= w_sum_next;
        end
        S_WR: begin
          r_ptr <= r_ptr + 1'b1;
          r_rem <= r_rem - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = r_ready;
    ram_we    = 1'b0;
    ram_addr  = r_ptr;
    ram_din   = '0;
    cpu_rst   = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (r_state)
      S_WR: begin
        ram_we  = 1'b1;
        ram_din = {r_hi, r_lo};
      end
      S_RUN: begin
        ram_we    = cpu_wrEn;
        ram_addr  = cpu_addr;
        ram_din   = cpu_data;
        cpu_rst   = 1'b0;
        load_done = 1'b1;
      end
      S_ERR: load_err = 1'b1;
      default: ;
    endcase
  end

endmodule
